// File: rtl/miner_pkg.sv
// Shared types and widths for the miner work controller and its result FIFO.
package miner_pkg;

  localparam int MIDSTATE_W = 256;
  localparam int DATA_W     = 512;
  localparam int NONCE_W    = 32;
  localparam int RES_JOB_W  = 16;
  localparam int HASH_CNT_W = 48;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    MINE = 2'd2
  } state_t;

  // Job field sized for the widest supported tag; narrower tags are zero-extended.
  typedef struct packed {
    logic [RES_JOB_W-1:0] job;
    logic [NONCE_W-1:0]   nonce;
  } result_t;

  function automatic logic [NONCE_W-1:0] correct_nonce(
    input logic [NONCE_W-1:0] raw,
    input logic [NONCE_W-1:0] offset
  );
    return raw - offset;
  endfunction

endpackage

// File: rtl/miner_result_fifo.sv
// Synchronous show-ahead result FIFO; a push into a full FIFO succeeds only
// when a pop happens in the same cycle.
module miner_result_fifo
  import miner_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic    clk,
  input  logic    reset_n,
  input  logic    push,
  input  result_t push_data,
  input  logic    pop,
  output result_t head,
  output logic    empty,
  output logic    full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W + 1)'(1);
  localparam logic [PTR_W:0]   CNT_FULL = (PTR_W + 1)'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  result_t          mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             do_pop;
  logic             do_push;

  assign empty   = (count == '0);
  assign full    = (count == CNT_FULL);
  assign head    = mem[rd_ptr];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Storage, pointers and occupancy; contents are discarded on reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PTR_ONE;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/miner_work_ctrl.sv
// Work sequencing controller for one hashing core with a golden-nonce result FIFO.
// Optional hash-rate counter output enabled by defining MINER_HASHRATE_CNT_EN.
module miner_work_ctrl
  import miner_pkg::*;
#(
  parameter logic [NONCE_W-1:0] NONCE_OFFSET = 32'd0,
  parameter int                 FIFO_DEPTH   = 4,
  parameter int                 JOB_ID_W     = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  work_valid,
  output logic                  work_ready,
  input  logic [MIDSTATE_W-1:0] work_midstate,
  input  logic [DATA_W-1:0]     work_data,
  input  logic [NONCE_W-1:0]    work_nonce_start,
  input  logic [NONCE_W-1:0]    work_nonce_end,
  output logic [MIDSTATE_W-1:0] core_midstate,
  output logic [DATA_W-1:0]     core_data,
  output logic [NONCE_W-1:0]    core_nonce,
  output logic                  core_load,
  input  logic [NONCE_W-1:0]    core_nonce_cur,
  input  logic                  core_golden_valid,
  input  logic [NONCE_W-1:0]    core_golden_nonce,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [NONCE_W-1:0]    res_nonce,
  output logic [JOB_ID_W-1:0]   res_job,
  output logic                  busy,
  output logic                  job_done,
`ifdef MINER_HASHRATE_CNT_EN
  output logic [HASH_CNT_W-1:0] hash_cnt,
`endif
  output logic                  overflow
);

  localparam logic [JOB_ID_W-1:0] JOB_ONE = JOB_ID_W'(1);

  state_t               state;
  logic [NONCE_W-1:0]   nonce_end;
  logic [JOB_ID_W-1:0]  job_id;
  logic                 accept;
  logic                 capture;
  logic                 pop;
  logic                 drop;
  logic                 fifo_empty;
  logic                 fifo_full;
  result_t              push_data;
  result_t              head;
  logic                 unused_job_bits;

  // The core is busy latching its buses while core_load is high.
  assign work_ready = !core_load;
  assign accept     = work_valid && work_ready;
  // Core outputs are stale outside MINE, so golden pulses only count there.
  assign capture    = (state == MINE) && core_golden_valid;
  assign pop        = res_ready && res_valid;
  assign drop       = capture && fifo_full && !pop;

  assign res_valid       = !fifo_empty;
  assign res_nonce       = head.nonce;
  assign res_job         = head.job[JOB_ID_W-1:0];
  assign unused_job_bits = ^head.job;

  // Result entry: tag with the job that was mining when the pulse arrived.
  always_comb begin
    push_data       = '0;
    push_data.job   = RES_JOB_W'(job_id);
    push_data.nonce = correct_nonce(core_golden_nonce, NONCE_OFFSET);
  end

  // Work FSM: accept, one-cycle load strobe, then range tracking.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      core_midstate <= '0;
      core_data     <= '0;
      core_nonce    <= '0;
      core_load     <= 1'b0;
      nonce_end     <= '0;
      job_id        <= '0;
      busy          <= 1'b0;
      job_done      <= 1'b0;
    end else begin
      core_load <= 1'b0;
      job_done  <= 1'b0;
      if (accept) begin
        core_midstate <= work_midstate;
        core_data     <= work_data;
        core_nonce    <= work_nonce_start;
        nonce_end     <= work_nonce_end;
        job_id        <= job_id + JOB_ONE;
        core_load     <= 1'b1;
        busy          <= 1'b1;
        state         <= LOAD;
      end else begin
        case (state)
          IDLE: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
          LOAD: begin
            state <= MINE;
            busy  <= 1'b1;
          end
          MINE: begin
            // Exact match so ranges wrapping through zero still terminate.
            if (core_nonce_cur == nonce_end) begin
              job_done <= 1'b1;
              busy     <= 1'b0;
              state    <= IDLE;
            end else begin
              state <= MINE;
              busy  <= 1'b1;
            end
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  // Sticky drop flag; a drop in the accept cycle still belongs to this report.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (accept) begin
      overflow <= 1'b0;
    end else begin
      overflow <= overflow;
    end
  end

`ifdef MINER_HASHRATE_CNT_EN
  // Saturating count of MINE cycles; survives new work.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hash_cnt <= '0;
    end else if ((state == MINE) && (hash_cnt != '1)) begin
      hash_cnt <= hash_cnt + HASH_CNT_W'(1);
    end else begin
      hash_cnt <= hash_cnt;
    end
  end
`endif

  miner_result_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset_n  (reset_n),
    .push     (capture),
    .push_data(push_data),
    .pop      (pop),
    .head     (head),
    .empty    (fifo_empty),
    .full     (fifo_full)
  );

endmodule
